sram_port_arbiter: RTL

Shares one single-port synchronous SRAM between the instruction-fetch requester (IF stage) and the load/store requester (MEM stage) of the 5-stage CPU. It grants at most one access per cycle and routes the one-cycle-late SRAM read data back to the requester that issued the read. It also holds each port's last read word stable. Sits between the pipeline stages and the memory, in place of separate inst/data SRAM ports.

---
 rtl/sram_port_arbiter_if.sv | 35 +++
 rtl/sram_port_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the IF/MEM requester ports and the single-port SRAM port around sram_port_arbiter.
// slave = arbiter view; master = the pipeline/SRAM side that drives requests and read data.
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, sram_rdata,
    output inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
           sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport master (
    output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, sram_rdata,
    input  inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
           sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between IF and MEM requesters, routing read data back to the issuer.
// Optional macro SRAM_ARB_FAIRNESS_EN: starvation counter lets inst win after STARVE_MAX data grants.
module sram_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               resetn,
  sram_port_arbiter_if.slave bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("sram_port_arbiter: STARVE_MAX must be in 1..15");
  end

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_INST    = 2'd1,
    OWN_DATA_RD = 2'd2
  } owner_e;

  owner_e      owner, owner_nxt;
  logic        gnt_inst, gnt_data;
  logic        force_inst;
  logic [31:0] inst_hold, data_hold;

`ifdef SRAM_ARB_FAIRNESS_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!bus.inst_req || gnt_inst) begin
      starve_cnt <= '0;
    end else if (gnt_data && starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign force_inst = (starve_cnt == STARVE_LIM);
`else
  assign force_inst = 1'b0;
`endif

  // Grants are gated by resetn so nothing reaches the SRAM while reset is held.
  assign gnt_inst = resetn & bus.inst_req & (~bus.data_req | force_inst);
  assign gnt_data = resetn & bus.data_req & ~gnt_inst;

  assign bus.inst_gnt = gnt_inst;
  assign bus.data_gnt = gnt_data;
  assign bus.sram_en  = gnt_inst | gnt_data;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    bus.sram_wen   = '0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (gnt_data) begin
      bus.sram_wen   = bus.data_wen;
      bus.sram_addr  = bus.data_addr;
      bus.sram_wdata = bus.data_wdata;
    end else if (gnt_inst) begin
      bus.sram_addr  = bus.inst_addr;
    end
  end

  // Owner FSM: state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) owner <= OWN_NONE;
    else         owner <= owner_nxt;
  end

  // Owner FSM: next state. Writes complete at grant, so they leave nothing pending.
  always_comb begin
    owner_nxt = OWN_NONE;
    if (gnt_inst)                           owner_nxt = OWN_INST;
    else if (gnt_data && bus.data_wen == 0) owner_nxt = OWN_DATA_RD;
  end

  // Owner FSM: outputs. The returning word bypasses the hold register in its valid cycle.
  always_comb begin
    bus.inst_rvalid = 1'b0;
    bus.data_rvalid = 1'b0;
    bus.inst_rdata  = inst_hold;
    bus.data_rdata  = data_hold;
    case (owner)
      OWN_INST: begin
        bus.inst_rvalid = 1'b1;
        bus.inst_rdata  = bus.sram_rdata;
      end
      OWN_DATA_RD: begin
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = bus.sram_rdata;
      end
      default: ;
    endcase
  end

  // NOTE: the hold registers are plain flops, so they take the async reset (all outputs read 0 in reset).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_hold <= '0;
      data_hold <= '0;
    end else begin
      if (owner == OWN_INST)    inst_hold <= bus.sram_rdata;
      if (owner == OWN_DATA_RD) data_hold <= bus.sram_rdata;
    end
  end

endmodule
